// File: rtl/cmp_pkg.sv
// Shared types for the compare pipeline: mode encoding, flag bundle and mode decode.
package cmp_pkg;

  localparam int CMP_MODE_W = 3;

  typedef enum logic [CMP_MODE_W-1:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_mode_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  // Encodings 6 and 7 are reserved; they select a false result and raise err.
  function automatic logic mode_reserved(input logic [CMP_MODE_W-1:0] mode);
    return (mode > CMP_GEU);
  endfunction

  function automatic logic mode_result(input logic [CMP_MODE_W-1:0] mode,
                                       input cmp_flags_t           flags);
    case (mode)
      CMP_EQ:  return flags.eq;
      CMP_NE:  return !flags.eq;
      CMP_LT:  return flags.lt;
      CMP_GE:  return !flags.lt;
      CMP_LTU: return flags.ltu;
      CMP_GEU: return !flags.ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude/equality comparator producing eq, signed lt and unsigned lt.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_flags_t       flags
);

  always_comb begin
    flags     = '0;
    flags.eq  = (a == b);
    flags.ltu = (a < b);
    flags.lt  = ($signed(a) < $signed(b));
  end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator with valid/ready handshake and a saturating hit counter.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [CMP_MODE_W-1:0] mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_result,
  output logic                  out_eq,
  output logic                  out_lt,
  output logic                  out_ltu,
  output logic                  out_err,
  input  logic                  clr_count,
  output logic [CNT_W-1:0]      hit_count
);

  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [CMP_MODE_W-1:0] s1_mode;

  logic       s1_adv;
  logic       s2_adv;
  cmp_flags_t s1_flags;
  logic       s1_result;
  logic       s1_err;
  logic       hit_fire;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .flags (s1_flags)
  );

  always_comb begin
    s1_result = mode_result(s1_mode, s1_flags);
    s1_err    = mode_reserved(s1_mode);
  end

  // Operands are only sampled on an actual beat so idle inputs never propagate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= op_a;
        s1_b    <= op_b;
        s1_mode <= mode;
      end
    end
  end

  // Result fields only load with a live S1 beat, so they retain their value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_eq     <= 1'b0;
      out_lt     <= 1'b0;
      out_ltu    <= 1'b0;
      out_err    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s1_result;
        out_eq     <= s1_flags.eq;
        out_lt     <= s1_flags.lt;
        out_ltu    <= s1_flags.ltu;
        out_err    <= s1_err;
      end
    end
  end

  assign hit_fire = out_valid && out_ready && out_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (clr_count) begin
      hit_count <= '0;
    end else if (hit_fire && !(&hit_count)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe: driver pushes modelled results, a monitor pops and compares.
module tb_cmp_pipe;

  localparam int W        = 6;
  localparam int CW       = 2;
  localparam int CNT_MAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [2:0]    mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_result;
  logic          out_eq;
  logic          out_lt;
  logic          out_ltu;
  logic          out_err;
  logic          clr_count = 1'b0;
  logic [CW-1:0] hit_count;

  cmp_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_eq     (out_eq),
    .out_lt     (out_lt),
    .out_ltu    (out_ltu),
    .out_err    (out_err),
    .clr_count  (clr_count),
    .hit_count  (hit_count)
  );

  always #5 clk = ~clk;

  // f = {result, eq, lt, ltu, err}; stamp = edge index at which the beat was accepted
  typedef struct {
    int         stamp;
    logic [4:0] f;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   rp = 0;
  int   bp_from = 0;
  int   bp_to = 0;
  bit   mon_en = 1'b0;
  bit   stalled_prev = 1'b0;
  logic [4:0] prev_f = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] ref_model(input int a, input int b, input int m);
    int sa, sb;
    bit eq, lt, ltu, res, err;
    sa  = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb  = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    eq  = (a == b);
    lt  = (sa < sb);
    ltu = (a < b);
    err = (m >= 6);
    case (m)
      0:       res = eq;
      1:       res = !eq;
      2:       res = lt;
      3:       res = !lt;
      4:       res = ltu;
      5:       res = !ltu;
      default: res = 1'b0;
    endcase
    return {res, eq, lt, ltu, err};
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic bit ready_now();
    case (rp)
      0:       return 1'b1;
      1:       return !(cyc >= bp_from && cyc < bp_to);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic step(input bit v, input int a, input int b, input int m,
                      input bit clr, output bit acc);
    int ga, gb;
    @(negedge clk);
    ga        = v ? a : int'($urandom);
    gb        = v ? b : int'($urandom);
    in_valid  = v;
    op_a      = ga[W-1:0];
    op_b      = gb[W-1:0];
    mode      = m[2:0];
    clr_count = clr;
    out_ready = ready_now();
    #1;
    acc = v && in_ready;
    @(posedge clk);
    #1;
    if (acc) q.push_back('{stamp: cyc, f: ref_model(a, b, m)});
  endtask

  task automatic send(input int a, input int b, input int m);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 64) begin
      step(1'b1, a, b, m, 1'b0, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit clr);
    bit acc;
    repeat (n) step(1'b0, 0, 0, 0, clr, acc);
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (q.size() != 0 && tries < 100) begin
      idle(1, 1'b0);
      tries++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    idle(1, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hit_count", hit_count, 0);
    q.delete();
    model_cnt    = 0;
    stalled_prev = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: samples after the driver has settled each cycle, well clear of the rising edge.
  initial begin
    bit         ev;
    logic [4:0] f;
    exp_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        ev = (q.size() > 0) && ((cyc - q[0].stamp) >= 1);
        f  = {out_result, out_eq, out_lt, out_ltu, out_err};
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, (q.size() < 2) || out_ready);
        chk("hit_count", hit_count, model_cnt);
        if (stalled_prev && out_valid) chk("hold_stable", f, prev_f);
        if (ev && out_ready) begin
          e = q.pop_front();
          chk("result_fields", f, e.f);
          if (clr_count) model_cnt = 0;
          else if (e.f[4] && model_cnt < CNT_MAX) model_cnt++;
        end else if (clr_count) begin
          model_cnt = 0;
        end
        stalled_prev = ev && !out_ready;
        prev_f       = f;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int ra, rb, rm;
    bit acc;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_fields", {out_valid, out_result, out_eq, out_lt, out_ltu, out_err}, 0);
    chk("reset_hit_count", hit_count, 0);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    rp = 0;
    send(4, 10, 0);
    send(4, 20, 0);
    send(2, 2, 0);
    drain();

    send(63, 1, 2);
    send(63, 1, 4);
    send(63, 1, 3);
    send(63, 1, 5);
    drain();

    send(9, 9, 6);
    send(9, 9, 7);
    drain();

    idle(1, 1'b1);
    rp      = 1;
    bp_from = cyc + 3;
    bp_to   = cyc + 9;
    repeat (5) begin
      ra = $urandom_range(0, 63);
      send(ra, ra, 0);
    end
    drain();

    rp = 0;
    idle(1, 1'b1);
    repeat (5) send(7, 7, 0);
    send(5, 5, 0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    drain();

    rp = 2;
    repeat (500) begin
      ra = $urandom_range(0, 63);
      rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 63));
      rm = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, ra, rb, rm, $urandom_range(0, 31) == 0, acc);
    end
    drain();

    rp = 0;
    repeat (4) send(3, 3, 0);
    send(11, 11, 0);
    send(12, 12, 1);
    mid_reset();
    idle(3, 1'b0);
    send(1, 1, 0);
    send(1, 2, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
